// File: rtl/scan_mux_pkg.sv
// Shared mode and FSM state encodings for the scan_mux channel multiplexer.
package scan_mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

endpackage

// File: rtl/scan_mux_if.sv
// Channel inputs, controls and the valid/ready output port of scan_mux.
// Handshake: a sample transfers on a rising edge where out_valid && out_ready;
// out_data/out_ch are stable while out_valid is high and out_ready is low.
interface scan_mux_if #(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
);
    logic [N_CH*W-1:0] in_data;
    logic [SEL_W-1:0]  sel;
    logic              mode;
    logic [N_CH-1:0]   ch_mask;
    logic [W-1:0]      out_data;
    logic [SEL_W-1:0]  out_ch;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, sel, mode, ch_mask, out_ready,
        input  out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, sel, mode, ch_mask, out_ready,
        output out_data, out_ch, out_valid
    );
endinterface

// File: rtl/scan_mux_rr_find_next.sv
// Circular first-set search: lowest enabled channel at or after start, wrapping.
module scan_mux_rr_find_next #(
    parameter int N_CH  = 16,
    parameter int SEL_W = 4
) (
    input  logic [N_CH-1:0]  mask,
    input  logic [SEL_W-1:0] start,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N_CH);

    logic [N_CH-1:0]  win;
    logic [SEL_W-1:0] off;
    logic [SEL_W:0]   sum;

    always_comb begin
        // Doubling the mask turns the wrap-around into a plain shift.
        win   = N_CH'({mask, mask} >> start);
        off   = '0;
        found = 1'b0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (win[j]) begin
                off   = SEL_W'(j);
                found = 1'b1;
            end
        end
        sum = {1'b0, start} + {1'b0, off};
        idx = (sum >= N_EXT) ? SEL_W'(sum - N_EXT) : sum[SEL_W-1:0];
    end
endmodule

// File: rtl/scan_mux.sv
// N-channel registered mux with DIRECT select and round-robin SCAN modes,
// feeding a valid/ready output register.
module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int N_CH  = 16,
    parameter int W     = 1,
    parameter int SEL_W = 4
) (
    input  logic         clk,
    input  logic         rst,
    scan_mux_if.slave    bus,
    output state_t       state
);
    localparam logic [SEL_W:0]   N_EXT   = (SEL_W+1)'(N_CH);
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

    state_t           state_q, state_d;
    logic [W-1:0]     data_q, data_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic             valid_q, valid_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load_en;
    logic [SEL_W-1:0] dsel;
    logic [SEL_W-1:0] scan_idx;
    logic             scan_found;
    logic [SEL_W-1:0] ptr_next;

    scan_mux_rr_find_next #(.N_CH(N_CH), .SEL_W(SEL_W)) u_find (
        .mask  (bus.ch_mask),
        .start (ptr_q),
        .idx   (scan_idx),
        .found (scan_found)
    );

    assign load_en  = !valid_q || bus.out_ready;
    // Out-of-range selects (non power-of-two N_CH) clamp to the last channel.
    assign dsel     = ({1'b0, bus.sel} >= N_EXT) ? LAST_CH : bus.sel;
    assign ptr_next = (scan_idx == LAST_CH) ? '0 : scan_idx + 1'b1;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (load_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.mode == MODE_DIRECT) state_d = ST_DIRECT;
                    else if (scan_found)         state_d = ST_SCAN;
                    else                         state_d = ST_IDLE;
                end
                ST_DIRECT: begin
                    if (bus.mode == MODE_SCAN) state_d = scan_found ? ST_SCAN : ST_IDLE;
                end
                ST_SCAN: begin
                    if (bus.mode == MODE_DIRECT) state_d = ST_DIRECT;
                    else if (!scan_found)        state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase

            // The state being entered decides what this edge loads.
            case (state_d)
                ST_DIRECT: begin
                    data_d  = bus.in_data[int'(dsel)*W +: W];
                    ch_d    = dsel;
                    valid_d = 1'b1;
                end
                ST_SCAN: begin
                    data_d  = bus.in_data[int'(scan_idx)*W +: W];
                    ch_d    = scan_idx;
                    valid_d = 1'b1;
                    ptr_d   = ptr_next;
                end
                default: valid_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            ch_q    <= '0;
            valid_q <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_data  = data_q;
    assign bus.out_ch    = ch_q;
    assign bus.out_valid = valid_q;
    assign state         = state_q;
endmodule

// File: tb/tb_scan_mux.sv
// Directed bench for scan_mux: a 16x8 instance driven from a vector table and
// hand sequences, plus a 5x4 instance for select clamping and pointer wrap.
module tb_scan_mux;
    import scan_mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_mux_if #(.N_CH(16), .W(8), .SEL_W(4)) bus ();
    scan_mux_if #(.N_CH(5),  .W(4), .SEL_W(3)) bus5 ();
    state_t st, st5;

    scan_mux #(.N_CH(16), .W(8), .SEL_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .state(st)
    );
    scan_mux #(.N_CH(5), .W(4), .SEL_W(3)) dut5 (
        .clk(clk), .rst(rst), .bus(bus5), .state(st5)
    );

    typedef struct {
        logic        mode;
        logic [3:0]  sel;
        logic [15:0] mask;
        logic        ready;
        logic        exp_valid;
        logic [3:0]  exp_ch;
        logic [7:0]  exp_data;
        state_t      exp_state;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;
    logic [15:0] pat = 16'hA5C3;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic m, input logic [3:0] s, input logic [15:0] mk, input logic r);
        bus.mode      = m;
        bus.sel       = s;
        bus.ch_mask   = mk;
        bus.out_ready = r;
    endtask

    task automatic drive5(input logic m, input logic [2:0] s, input logic [4:0] mk, input logic r);
        bus5.mode      = m;
        bus5.sel       = s;
        bus5.ch_mask   = mk;
        bus5.out_ready = r;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] ch,
                             input logic [7:0] d, input state_t s);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_ch"},    32'(bus.out_ch),    32'(ch));
        check({tag, "_data"},  32'(bus.out_data),  32'(d));
        check({tag, "_state"}, 32'(st),            32'(s));
    endtask

    task automatic check_out5(input string tag, input logic v, input logic [2:0] ch,
                              input logic [3:0] d, input state_t s);
        check({tag, "_valid"}, 32'(bus5.out_valid), 32'(v));
        check({tag, "_ch"},    32'(bus5.out_ch),    32'(ch));
        check({tag, "_data"},  32'(bus5.out_data),  32'(d));
        check({tag, "_state"}, 32'(st5),            32'(s));
    endtask

    initial begin
        // mode, sel, mask, ready | valid, ch, data, state
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd0,  8'h10, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b0, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b0, 4'd9, 16'h0000, 1'b0, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b0, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd7,  8'h17, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd0,  8'h10, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0004, 1'b1, 1'b1, 4'd2,  8'h12, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0004, 1'b1, 1'b1, 4'd2,  8'h12, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd2,  8'h12, ST_IDLE});
        vecs.push_back('{1'b1, 4'd0, 16'h0000, 1'b1, 1'b0, 4'd2,  8'h12, ST_IDLE});
        vecs.push_back('{1'b1, 4'd0, 16'h0008, 1'b1, 1'b1, 4'd3,  8'h13, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0091, 1'b1, 1'b1, 4'd7,  8'h17, ST_SCAN});
        vecs.push_back('{1'b0, 4'd3, 16'h0091, 1'b1, 1'b1, 4'd3,  8'h13, ST_DIRECT});
        vecs.push_back('{1'b0, 4'd9, 16'h0091, 1'b1, 1'b1, 4'd9,  8'h19, ST_DIRECT});
        vecs.push_back('{1'b1, 4'd0, 16'h0591, 1'b1, 1'b1, 4'd8,  8'h18, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0591, 1'b1, 1'b1, 4'd10, 8'h1A, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0591, 1'b1, 1'b1, 4'd0,  8'h10, ST_SCAN});
        vecs.push_back('{1'b1, 4'd0, 16'h0591, 1'b1, 1'b1, 4'd4,  8'h14, ST_SCAN});
        vecs.push_back('{1'b0, 4'd1, 16'h0000, 1'b1, 1'b1, 4'd1,  8'h11, ST_DIRECT});
        vecs.push_back('{1'b1, 4'd1, 16'h0000, 1'b1, 1'b0, 4'd1,  8'h11, ST_IDLE});
        vecs.push_back('{1'b0, 4'd2, 16'h0000, 1'b1, 1'b1, 4'd2,  8'h12, ST_DIRECT});

        rst          = 1'b1;
        bus.in_data  = '0;
        bus5.in_data = 20'h54321;
        drive(1'b0, 4'd0, 16'h0000, 1'b1);
        drive5(1'b0, 3'd0, 5'b00000, 1'b1);
        step();
        step();
        check_out("reset", 1'b0, 4'd0, 8'h00, ST_IDLE);
        check_out5("reset5", 1'b0, 3'd0, 4'h0, ST_IDLE);
        rst = 1'b0;

        // DIRECT: each channel carries one bit of the pattern
        for (int k = 0; k < 16; k++) bus.in_data[k*8 +: 8] = {7'b0, pat[k]};
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 4'(k), 16'h0000, 1'b1);
            step();
            check_out($sformatf("direct%0d", k), 1'b1, 4'(k), {7'b0, pat[k]}, ST_DIRECT);
        end

        // Table: scan walk, back-pressure, mask changes, idle and mode switches
        for (int k = 0; k < 16; k++) bus.in_data[k*8 +: 8] = 8'(k + 16);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].mode, vecs[i].sel, vecs[i].mask, vecs[i].ready);
            step();
            check_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_ch,
                      vecs[i].exp_data, vecs[i].exp_state);
        end

        // Reset while stalled: pointer sits at 5 before the reset
        drive(1'b1, 4'd0, 16'h0091, 1'b1);
        step();
        check_out("pre_stall", 1'b1, 4'd7, 8'h17, ST_SCAN);
        drive(1'b1, 4'd0, 16'h0091, 1'b0);
        step();
        check_out("stall_hold", 1'b1, 4'd7, 8'h17, ST_SCAN);
        rst = 1'b1;
        step();
        check_out("stall_rst", 1'b0, 4'd0, 8'h00, ST_IDLE);
        rst = 1'b0;
        drive(1'b1, 4'd0, 16'h0091, 1'b1);
        step();
        check_out("post_rst0", 1'b1, 4'd0, 8'h10, ST_SCAN);
        step();
        check_out("post_rst1", 1'b1, 4'd4, 8'h14, ST_SCAN);

        // Five-channel instance: select clamping and circular wrap at N_CH-1
        rst = 1'b1;
        step();
        check_out5("r5", 1'b0, 3'd0, 4'h0, ST_IDLE);
        rst = 1'b0;
        drive5(1'b0, 3'd2, 5'b00000, 1'b1);
        step();
        check_out5("d5_sel2", 1'b1, 3'd2, 4'h3, ST_DIRECT);
        drive5(1'b0, 3'd4, 5'b00000, 1'b1);
        step();
        check_out5("d5_sel4", 1'b1, 3'd4, 4'h5, ST_DIRECT);
        drive5(1'b0, 3'd5, 5'b00000, 1'b1);
        step();
        check_out5("d5_sel5", 1'b1, 3'd4, 4'h5, ST_DIRECT);
        drive5(1'b0, 3'd7, 5'b00000, 1'b1);
        step();
        check_out5("d5_sel7", 1'b1, 3'd4, 4'h5, ST_DIRECT);
        drive5(1'b1, 3'd0, 5'b10001, 1'b1);
        step();
        check_out5("s5_a", 1'b1, 3'd0, 4'h1, ST_SCAN);
        step();
        check_out5("s5_b", 1'b1, 3'd4, 4'h5, ST_SCAN);
        step();
        check_out5("s5_wrap", 1'b1, 3'd0, 4'h1, ST_SCAN);
        drive5(1'b1, 3'd0, 5'b00100, 1'b1);
        step();
        check_out5("s5_single", 1'b1, 3'd2, 4'h3, ST_SCAN);
        step();
        check_out5("s5_repeat", 1'b1, 3'd2, 4'h3, ST_SCAN);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/scan_mux.md
Name: scan_mux

Overview:
- Parametrised N-channel, W-bit registered multiplexer; successor to the fixed 16:1 single-bit mux.
- Two modes:
  - DIRECT: external select, registered output.
  - SCAN: internal round-robin walk over a channel-enable mask.
- Output side uses a valid/ready handshake, so the block can feed serialisers, test-pattern capture or status-collection logic that back-pressures.

Parameters:
- N_CH, 16, number of input channels (2..256).
- W, 1, bits per channel.
- SEL_W, 4, select/pointer width; must equal clog2(N_CH).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  N_CH*W  packed channels; channel k = in_data[k*W +: W].
- sel  input  SEL_W  channel select, used in DIRECT mode only.
- mode  input  1  0 = DIRECT, 1 = SCAN.
- ch_mask  input  N_CH  channel enables, used in SCAN mode only; bit k enables channel k.
- out_data  output  W  registered selected data.
- out_ch  output  SEL_W  index of the channel held in out_data.
- out_valid  output  1  out_data/out_ch hold a valid sample.
- out_ready  input  1  consumer accepts the sample when out_valid && out_ready.

Behaviour:
Reset (rst=1 at a clock edge):
- out_data=0, out_ch=0, out_valid=0, scan pointer ptr=0, state=IDLE.
- Reset has priority over every other input, including mid-stall.

Load rule:
- The output register loads when load_en = !out_valid || out_ready.
- When load_en=0 (stall), out_data, out_ch, out_valid, ptr and state all hold; in_data, sel, mode and ch_mask are ignored.

FSM states and transitions, evaluated only when load_en=1:
- IDLE: mode=0 -> DIRECT; mode=1 and ch_mask!=0 -> SCAN; mode=1 and ch_mask==0 -> stay IDLE. out_valid stays 0 while in IDLE.
- DIRECT: mode=1 -> SCAN, or IDLE if ch_mask==0; otherwise stay.
- SCAN: mode=0 -> DIRECT; ch_mask==0 -> IDLE; otherwise stay.
- Each transition takes effect at the same edge as the load it selects. The mode and mask sampled at that edge decide both the next state and what is loaded.

DIRECT load:
- out_data <= channel sel; out_ch <= sel; out_valid <= 1.
- Latency: 1 cycle from sel/in_data to out_data.
- sel >= N_CH (only possible when N_CH is not a power of 2) selects channel N_CH-1, and out_ch reports N_CH-1.

SCAN load:
- c = first channel with ch_mask[c]=1, searching circularly from ptr upward (ptr, ptr+1, ..., N_CH-1, 0, ...).
- out_data <= channel c; out_ch <= c; out_valid <= 1; ptr <= (c+1) mod N_CH.
- A single enabled channel is loaded on every accepted cycle.
- Mask changes apply from the next load. A cleared bit at ptr is skipped, with no bubble.
- Entering SCAN from DIRECT or IDLE does not reset ptr; the walk resumes where it left off.

Load that targets IDLE (mode=1, ch_mask==0):
- out_valid <= 0. out_data and out_ch hold their last values.

Throughput:
- With out_ready held at 1, one sample per cycle with no bubbles in either mode.

Decomposition:
- Shared package/header holds:
  - MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
  - State encodings ST_IDLE=2'd0, ST_DIRECT=2'd1, ST_SCAN=2'd2.
- One sub-module, rr_find_next:
  - Purely combinational circular first-set search.
  - Inputs: mask[N_CH], start[SEL_W]. Outputs: idx[SEL_W], found.
  - Implemented as a double-width mask priority encode.
- scan_mux contains the FSM, the output register and the handshake.

Test Plan:
- Reset/DIRECT: rst high 2 cycles, then mode=0, out_ready=1, N_CH=16, W=1, in_data=16'hA5C3, sel stepping 0..15 -> out_data follows the bits of 16'hA5C3 one cycle later; out_ch=sel delayed by 1; out_valid=1 from the first post-reset edge.
- Scan walk: W=8, ch_mask=16'h0091 (ch 0, 4, 7), channel k data = k+8'h10, out_ready=1 -> out_ch sequence 0,4,7,0,4,7 with out_data 8'h10, 8'h14, 8'h17, repeating, no bubbles.
- Back-pressure: scan running, out_ready=0 for 3 cycles while out_ch=4 -> out_data=8'h14, out_ch=4 and out_valid held 3 cycles; after out_ready=1 the next out_ch is 7.
- Mask change/empty: mid-scan with ptr=5, ch_mask changes to 16'h0004 -> next out_ch=2, then 2 repeatedly. ch_mask=0 -> out_valid falls 1 cycle later and state is IDLE. ch_mask=16'h0008 -> out_valid=1 with out_ch=3 the following cycle.
- Mode switch: in SCAN with out_ch=7, set mode=0, sel=3 -> next out_ch=3. Return mode=1 -> scan resumes at the first enabled channel at or after 8.
- Reset mid-stall: out_valid=1, out_ready=0, assert rst -> out_valid=0, out_ch=0, out_data=0 at that edge; the next scan starts from channel 0.
